// File: rtl/csp_rr_arbiter_if.sv
// Request/output channel bundle for the round-robin arbiter.
// master = requesters plus downstream sink side, slave = arbiter side.
interface csp_rr_arbiter_if #(
  parameter int WIDTH   = 11,
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     out_valid;
  logic [WIDTH-1:0]         out_data;
  logic [IDW-1:0]           out_grant;
  logic                     out_ready;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_grant
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_grant
  );
endinterface

// File: rtl/csp_rr_arbiter.sv
// Round-robin arbiter merging NUM_REQ single-flit channels into one registered
// output stage; the stage may drain and refill on the same edge.
module csp_rr_arbiter #(
  parameter int WIDTH   = 11,
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  csp_rr_arbiter_if.slave    bus,
  output logic [CNT_W-1:0]   pkt_count
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_data;
  logic [IDW-1:0]     r_grant;
  logic [IDW-1:0]     r_ptr;
  logic [CNT_W-1:0]   r_cnt;

  state_t             w_state_nxt;
  logic               w_out_valid;
  logic               w_load_en;
  logic               w_found;
  logic [IDW-1:0]     w_win;
  logic               w_accept;
  logic [IDW:0]       w_sum;
  logic [IDW:0]       w_idx;
  logic [NUM_REQ-1:0] w_req_ready;

  assign w_out_valid = (r_state == ST_FULL);
  assign w_load_en   = !w_out_valid || bus.out_ready;
  assign w_accept    = w_found && w_load_en && reset;

  // Scan requesters starting at the pointer; the first valid one wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_sum >= (IDW+1)'(NUM_REQ)) begin
        w_idx = w_sum - (IDW+1)'(NUM_REQ);
      end else begin
        w_idx = w_sum;
      end
      if (!w_found && bus.req_valid[w_idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[IDW-1:0];
      end else begin
        w_found = w_found;
      end
    end
  end

  // One-hot accept for the winner only while the output stage can load.
  always_comb begin
    w_req_ready = '0;
    if (w_accept) begin
      w_req_ready[w_win] = 1'b1;
    end else begin
      w_req_ready = '0;
    end
  end

  // Occupancy state: fill on grant, empty on drain without refill.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_FULL;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (bus.out_ready && !w_accept) begin
          w_state_nxt = ST_EMPTY;
        end else begin
          w_state_nxt = ST_FULL;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // State register; reset discards any held packet without counting it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
      r_grant <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_data  <= bus.req_data[int'(w_win)*WIDTH +: WIDTH];
        r_grant <= w_win;
        r_ptr   <= (w_win == IDW'(NUM_REQ - 1)) ? '0 : w_win + IDW'(1);
      end
      if (w_out_valid && bus.out_ready) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_data;
  assign bus.out_grant = r_grant;
  assign pkt_count     = r_cnt;

endmodule

// File: tb/tb_csp_rr_arbiter.sv
// Directed bench for csp_rr_arbiter: vector table plus hand-written sequences
// for back-to-back, reset and counter wrap (CNT_W=4).
module tb_csp_rr_arbiter;

  localparam logic [10:0] P0 = 11'b01000_000_010;
  localparam logic [10:0] P1 = 11'b01000_001_010;
  localparam logic [10:0] P2 = 11'b10000_011_010;
  localparam logic [10:0] P3 = 11'b00110_100_010;

  typedef struct {
    logic        rst_n;
    logic [3:0]  vld;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [1:0]  exp_gnt;
    logic [10:0] exp_data;
    logic [3:0]  exp_cnt;
    logic [1:0]  exp_ptr;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] pkt_count;
  int         n_tests;
  int         n_fail;
  vec_t       vt[$];

  csp_rr_arbiter_if #(.WIDTH(11), .NUM_REQ(4), .IDW(2)) ifc ();

  csp_rr_arbiter #(.WIDTH(11), .NUM_REQ(4), .IDW(2), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .bus       (ifc.slave),
    .pkt_count (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic addv(input logic r, input logic [3:0] v, input logic o, input logic [3:0] er,
                      input logic eov, input logic [1:0] eg, input logic [10:0] ed,
                      input logic [3:0] ec, input logic [1:0] ep);
    vec_t t;
    t.rst_n = r; t.vld = v; t.ordy = o; t.exp_rdy = er; t.exp_ov = eov;
    t.exp_gnt = eg; t.exp_data = ed; t.exp_cnt = ec; t.exp_ptr = ep;
    vt.push_back(t);
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ifc.req_valid = 4'b0000;
    ifc.out_ready = 1'b0;
    edge_wait();
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    ifc.req_valid = 4'b0000;
    ifc.req_data  = 44'd0;
    ifc.out_ready = 1'b0;
    edge_wait();

    // Single requester, back-to-back packets from requester 2.
    do_reset();
    ifc.req_data = {P3, 11'b01000_000_010, P1, P0};
    ifc.req_valid = 4'b0100;
    ifc.out_ready = 1'b1;
    #2;
    chk("b2b rdy1", 32'(ifc.req_ready), 32'h4);
    edge_wait();
    chk("b2b ov1", 32'(ifc.out_valid), 32'h1);
    chk("b2b gnt1", 32'(ifc.out_grant), 32'h2);
    chk("b2b data1", 32'(ifc.out_data), 32'(11'b01000_000_010));
    ifc.req_data = {P3, 11'b01100_000_011, P1, P0};
    #2;
    chk("b2b rdy2", 32'(ifc.req_ready), 32'h4);
    edge_wait();
    chk("b2b gnt2", 32'(ifc.out_grant), 32'h2);
    chk("b2b data2", 32'(ifc.out_data), 32'(11'b01100_000_011));
    chk("b2b cnt1", 32'(pkt_count), 32'h1);
    ifc.req_valid = 4'b0000;
    edge_wait();
    chk("b2b cnt2", 32'(pkt_count), 32'h2);
    chk("b2b ov0", 32'(ifc.out_valid), 32'h0);
    chk("b2b ptr", 32'(dut.r_ptr), 32'h3);

    // Vector table: reset, all-four, backpressure, fairness, mid-op reset.
    ifc.req_data = {P3, P2, P1, P0};
    addv(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 11'd0, 4'd0, 2'd0);
    addv(1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 11'd0, 4'd0, 2'd0);
    addv(1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, P0,    4'd0, 2'd1);
    addv(1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, P1,    4'd1, 2'd2);
    addv(1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, P2,    4'd2, 2'd3);
    addv(1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, P3,    4'd3, 2'd0);
    addv(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, P3,    4'd4, 2'd0);
    addv(1'b1, 4'b1010, 1'b0, 4'b0010, 1'b1, 2'd1, P1,    4'd4, 2'd2);
    for (int s = 0; s < 5; s++) begin
      addv(1'b1, 4'b1010, 1'b0, 4'b0000, 1'b1, 2'd1, P1, 4'd4, 2'd2);
    end
    addv(1'b1, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, P3,    4'd5, 2'd0);
    addv(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, P3,    4'd6, 2'd0);
    addv(1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, P0,    4'd6, 2'd1);
    addv(1'b1, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, P3,    4'd7, 2'd0);
    addv(1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, P0,    4'd8, 2'd1);
    addv(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, P0,    4'd8, 2'd1);
    addv(1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 2'd0, 11'd0, 4'd0, 2'd0);
    addv(1'b1, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, P0,    4'd0, 2'd1);
    addv(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, P0,    4'd1, 2'd1);

    foreach (vt[i]) begin
      rst_n = vt[i].rst_n;
      ifc.req_valid = vt[i].vld;
      ifc.out_ready = vt[i].ordy;
      #2;
      chk($sformatf("v%0d rdy", i), 32'(ifc.req_ready), 32'(vt[i].exp_rdy));
      edge_wait();
      chk($sformatf("v%0d ov", i), 32'(ifc.out_valid), 32'(vt[i].exp_ov));
      chk($sformatf("v%0d gnt", i), 32'(ifc.out_grant), 32'(vt[i].exp_gnt));
      chk($sformatf("v%0d data", i), 32'(ifc.out_data), 32'(vt[i].exp_data));
      chk($sformatf("v%0d cnt", i), 32'(pkt_count), 32'(vt[i].exp_cnt));
      chk($sformatf("v%0d ptr", i), 32'(dut.r_ptr), 32'(vt[i].exp_ptr));
    end

    // Counter wrap: 17 deliveries from requester 1 with no gaps.
    do_reset();
    ifc.req_valid = 4'b0010;
    ifc.out_ready = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      #2;
      chk($sformatf("wrap rdy%0d", k), 32'(ifc.req_ready), 32'h2);
      edge_wait();
      chk($sformatf("wrap ov%0d", k), 32'(ifc.out_valid), 32'h1);
      chk($sformatf("wrap cnt%0d", k), 32'(pkt_count), 32'((k - 1) % 16));
    end
    ifc.req_valid = 4'b0000;
    edge_wait();
    chk("wrap final cnt", 32'(pkt_count), 32'h1);
    chk("wrap final ov", 32'(ifc.out_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/csp_rr_arbiter.md
Name: csp_rr_arbiter

Overview:
- Synchronous round-robin arbiter that shares one router output channel among NUM_REQ input channels.
- One instance per tree-node output port. It carries single-flit 11-bit packets: [10:6] routing, [5:3] source id, [2:0] destination id.
- Packet data passes through unmodified, registered in a single output stage.
- It replaces the implicit merge in the node and guarantees bounded wait for every requester.

Parameters:
- WIDTH, 11: packet width in bits.
- NUM_REQ, 4: number of requesting input channels (2..8).
- IDW, 2: grant index width, equal to clog2(NUM_REQ).
- CNT_W, 16: packet counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous active-low reset: sampled on the rising edge of clk, state is cleared when low.
- req_valid  in  NUM_REQ  per-requester valid.
- req_data  in  NUM_REQ*WIDTH  packets; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  out  NUM_REQ  one-hot accept; transfer on requester i when req_valid[i] and req_ready[i] are both high at the clock edge.
- out_valid  out  1  output register holds a packet.
- out_data  out  WIDTH  registered packet.
- out_grant  out  IDW  index of the requester whose packet is in out_data.
- out_ready  in  1  downstream accept; transfer when out_valid and out_ready are both high.
- pkt_count  out  CNT_W  number of packets delivered downstream; wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset low at an edge):
  - out_valid=0, out_data=0, out_grant=0, pkt_count=0.
  - Round-robin pointer ptr=0.
  - Reset dominates all other events in that cycle. A packet held in the output register is discarded and does not increment pkt_count.
  - req_ready is forced to 0 while reset is low.
- load_en = !out_valid || out_ready (combinational). The register may refill in the same cycle it drains, giving 1 packet/cycle sustained throughput.
- Winner selection (combinational):
  - Scan requesters ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1 modulo NUM_REQ.
  - The first index with req_valid high wins.
  - With no valid requester there is no winner and req_ready is all zero.
- req_ready[w] = load_en && reset; high only for the winner w, zero elsewhere.
- On an edge with an accepted transfer from winner w:
  - out_data <= req_data[w], out_grant <= w, out_valid <= 1.
  - ptr <= (w+1) mod NUM_REQ; this wraps from NUM_REQ-1 to 0.
- On an edge with out_valid && out_ready and no new winner: out_valid <= 0.
  - out_data and out_grant hold their last values.
- On an edge with out_valid && !out_ready: out_data, out_grant, out_valid and ptr hold.
  - All req_ready are 0 during this stall.
- pkt_count increments by 1 on every edge with out_valid && out_ready, including when a refill happens in the same cycle. All-ones wraps to 0.
- ptr changes only on an accepted grant, never on idle cycles.
- Latency: a packet accepted at edge k is visible on out_data after edge k and can leave at edge k+1 at the earliest.
- Fairness: a requester holding req_valid is granted within NUM_REQ accepted transfers.
- Protocol:
  - Requesters keep req_valid high and req_data stable until accepted; the block does not latch unaccepted data.
  - Deasserting req_valid before acceptance withdraws the request, with no state effect.
- State machine, two states encoded by out_valid:
  - EMPTY → FULL on a grant.
  - FULL → FULL on drain with refill, or on stall.
  - FULL → EMPTY on drain without refill.
- Edge cases:
  - NUM_REQ not a power of two: ptr wraps at NUM_REQ. Index values of NUM_REQ and above never appear on out_grant.
  - req_data of a non-granted requester never reaches out_data.

Test Plan:
- Single requester, back-to-back:
  - Stimulus: requester 2 sends 11'b01000_000_010, then 11'b01100_000_011, with out_ready=1 throughout.
  - Required: out_data shows each packet one cycle after acceptance; out_grant=2; pkt_count reaches 2; ptr=3.
- All four requesters simultaneously:
  - Stimulus: all assert from reset with packets 11'b01000_000_010 (0), 11'b01000_001_010 (1), 11'b10000_011_010 (2), 11'b00110_100_010 (3); out_ready=1.
  - Required: out_grant sequence 0,1,2,3 on consecutive cycles; pkt_count=4; ptr wraps to 0.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles while requesters 1 and 3 are valid.
  - Required: out_data and out_grant are stable, all req_ready=0, pkt_count unchanged.
  - Then out_ready=1: the next grant goes to the requester following the held one in round-robin order, and refill happens in the same cycle as the drain.
- Fairness under saturation:
  - Stimulus: requester 0 is continuously valid; requester 3 asserts once.
  - Required: requester 3 is granted within 4 transfers and the grants alternate 0,3,0.
- Reset mid-operation:
  - Stimulus: assert reset (low) while out_valid=1 and out_ready=0.
  - Required: the next edge gives out_valid=0, pkt_count=0, ptr=0; the held packet never appears downstream.
  - After release, requester 0 wins first.
- Counter wrap:
  - Stimulus: CNT_W=4, 17 packets delivered.
  - Required: pkt_count reads 1; there are no gaps in delivery.
